pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 49 ++++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 129 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encoding, timing defaults and output decode for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int STATE_W           = 3;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_STABLE_CYCLES = 256;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  typedef struct packed {
    logic pll_resetb;
    logic pll_bypass;
    logic sys_rst;
    logic ready;
    logic fault;
  } seq_out_t;

  // fault_settled: in FAULT, the datapath may leave reset once the bypassed clock has settled
  function automatic seq_out_t decode_outputs(input pll_state_e st, input logic fault_settled);
    seq_out_t o;
    o = '{pll_resetb: 1'b0, pll_bypass: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
    case (st)
      RESET_PLL: o.pll_resetb = 1'b0;
      WAIT_LOCK, STABLE: o.pll_resetb = 1'b1;
      RUN: begin
        o.pll_resetb = 1'b1;
        o.sys_rst    = 1'b0;
        o.ready      = 1'b1;
      end
      FAULT: begin
        o.pll_bypass = 1'b1;
        o.fault      = 1'b1;
        o.sys_rst    = ~fault_settled;
      end
      default: o.pll_resetb = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL out of reset, qualifies lock, gates the system reset and falls
// back to PLL bypass after repeated lock failures.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_i,
  input  logic               retry_i,
  output logic               pll_resetb_o,
  output logic               pll_bypass_o,
  output logic               sys_rst_o,
  output logic               ready_o,
  output logic               fault_o,
  output logic [STATE_W-1:0] state_o,
  output logic [1:0]         retry_cnt_o
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_FULL = CNT_W'(STABLE_CYCLES);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  logic       lock_s;
  pll_state_e state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0] retry_cnt_r, retry_cnt_s;
  seq_out_t   out_r, out_s;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_i),
    .q   (lock_s)
  );

  // state, counter, retry count and outputs all update on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RESET_PLL;
      cnt_r       <= '0;
      retry_cnt_r <= 2'd0;
      out_r       <= decode_outputs(RESET_PLL, 1'b0);
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      retry_cnt_r <= retry_cnt_s;
      out_r       <= out_s;
    end
  end

  // next-state, counter and retry bookkeeping
  always_comb begin
    state_s     = state_r;
    retry_cnt_s = retry_cnt_r;
    cnt_s       = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
    case (state_r)
      RESET_PLL: begin
        if (cnt_r >= RST_LAST) state_s = WAIT_LOCK;
        else                   state_s = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_s = STABLE;
        end else if (cnt_r >= TMO_LAST) begin
          if (retry_cnt_r < RETRY_MAX) begin
            retry_cnt_s = retry_cnt_r + 2'd1;
            state_s     = RESET_PLL;
          end else begin
            state_s = FAULT;
          end
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_s = WAIT_LOCK;
        end else if (cnt_r >= STABLE_LAST) begin
          state_s     = RUN;
          retry_cnt_s = 2'd0;
        end else begin
          state_s = STABLE;
        end
      end
      RUN: begin
        if (retry_i) begin
          state_s     = RESET_PLL;
          retry_cnt_s = 2'd0;
        end else if (!lock_s) begin
          state_s = RESET_PLL;
        end else begin
          state_s = RUN;
        end
      end
      FAULT: begin
        if (retry_i) begin
          state_s     = RESET_PLL;
          retry_cnt_s = 2'd0;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s     = RESET_PLL;
        retry_cnt_s = 2'd0;
      end
    endcase
    if (state_s != state_r) cnt_s = '0;
    else                    cnt_s = cnt_s;
    out_s = decode_outputs(state_s, (cnt_s >= STABLE_FULL));
  end

  assign pll_resetb_o = out_r.pll_resetb;
  assign pll_bypass_o = out_r.pll_bypass;
  assign sys_rst_o    = out_r.sys_rst;
  assign ready_o      = out_r.ready;
  assign fault_o      = out_r.fault;
  assign state_o      = state_r;
  assign retry_cnt_o  = retry_cnt_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expected output-change events are queued with their cycle
// number; a monitor pops and compares whenever the DUT outputs change.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_lock_i = 1'b0;
  logic retry_i = 1'b0;
  logic pll_resetb_o, pll_bypass_o, sys_rst_o, ready_o, fault_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // flags = {pll_resetb, pll_bypass, sys_rst, ready, fault}
  localparam logic [4:0] F_RST   = 5'b00100;
  localparam logic [4:0] F_WAIT  = 5'b10100;
  localparam logic [4:0] F_RUN   = 5'b10010;
  localparam logic [4:0] F_FLT_H = 5'b01101;
  localparam logic [4:0] F_FLT_L = 5'b01001;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [4:0] flags;
    logic [1:0] rc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pll_reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock_i   (pll_lock_i),
    .retry_i      (retry_i),
    .pll_resetb_o (pll_resetb_o),
    .pll_bypass_o (pll_bypass_o),
    .sys_rst_o    (sys_rst_o),
    .ready_o      (ready_o),
    .fault_o      (fault_o),
    .state_o      (state_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [9:0] cur_v, prev_v, want_v;
  exp_t       ev;

  always @(negedge clk) begin
    cur_v = {state_o, pll_resetb_o, pll_bypass_o, sys_rst_o, ready_o, fault_o, retry_cnt_o};
    if (mon_en && cur_v !== prev_v) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur_v);
      end else begin
        ev = exp_q.pop_front();
        want_v = {ev.st, ev.flags, ev.rc};
        if (cur_v !== want_v || cyc != ev.cyc) begin
          bad++;
          $display("FAIL event got cyc=%0d out=%b want cyc=%0d out=%b", cyc, cur_v, ev.cyc, want_v);
        end
      end
    end
    prev_v = cur_v;
  end

  task automatic push(input int c, input logic [2:0] st, input logic [4:0] fl, input logic [1:0] rc);
    exp_t e;
    e.cyc = c; e.st = st; e.flags = fl; e.rc = rc;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_to(input int n);
    do @(negedge clk); while (cyc < n);
    #2;
  endtask

  function automatic logic [31:0] out_word();
    return {22'd0, state_o, pll_resetb_o, pll_bypass_o, sys_rst_o, ready_o, fault_o, retry_cnt_o};
  endfunction

  localparam logic [31:0] RESET_WORD = 32'b0000000000000000000000_000_00100_00;

  task automatic start(input logic lock);
    mon_en = 1'b0;
    rst = 1'b1;
    pll_lock_i = lock;
    retry_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_values", out_word(), RESET_WORD);
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // lock held from reset, lock loss in RUN, retry in RUN
    start(1'b1);
    push(16, 3'd1, F_WAIT, 2'd0);
    push(17, 3'd2, F_WAIT, 2'd0);
    push(273, 3'd3, F_RUN, 2'd0);
    wait_to(300);
    pll_lock_i = 1'b0;
    push(303, 3'd0, F_RST, 2'd0);
    wait_to(302);
    check("sysrst_low_before_loss", {31'd0, sys_rst_o}, 32'd0);
    wait_to(305);
    pll_lock_i = 1'b1;
    push(319, 3'd1, F_WAIT, 2'd0);
    push(320, 3'd2, F_WAIT, 2'd0);
    push(576, 3'd3, F_RUN, 2'd0);
    wait_to(600);
    retry_i = 1'b1;
    push(601, 3'd0, F_RST, 2'd0);
    wait_to(601);
    retry_i = 1'b0;
    push(617, 3'd1, F_WAIT, 2'd0);
    push(618, 3'd2, F_WAIT, 2'd0);
    push(874, 3'd3, F_RUN, 2'd0);
    wait_to(880);
    check("drain_s1", exp_q.size(), 32'd0);

    // lock never asserts: retries, fault, retry out of fault
    start(1'b0);
    push(16, 3'd1, F_WAIT, 2'd0);
    wait_to(100);
    retry_i = 1'b1;
    wait_to(101);
    retry_i = 1'b0;
    wait_to(103);
    check("retry_ignored_wait", {29'd0, state_o}, 32'd1);
    push(4112, 3'd0, F_RST, 2'd1);
    push(4128, 3'd1, F_WAIT, 2'd1);
    push(8224, 3'd0, F_RST, 2'd2);
    push(8240, 3'd1, F_WAIT, 2'd2);
    push(12336, 3'd0, F_RST, 2'd3);
    push(12352, 3'd1, F_WAIT, 2'd3);
    push(16448, 3'd4, F_FLT_H, 2'd3);
    push(16704, 3'd4, F_FLT_L, 2'd3);
    wait_to(16703);
    check("fault_sysrst_hold", {31'd0, sys_rst_o}, 32'd1);
    wait_to(16710);
    retry_i = 1'b1;
    push(16711, 3'd0, F_RST, 2'd0);
    wait_to(16711);
    retry_i = 1'b0;
    push(16727, 3'd1, F_WAIT, 2'd0);
    wait_to(16730);
    check("drain_s2", exp_q.size(), 32'd0);

    // one-cycle lock glitch at STABLE count 100
    start(1'b1);
    push(16, 3'd1, F_WAIT, 2'd0);
    push(17, 3'd2, F_WAIT, 2'd0);
    wait_to(117);
    pll_lock_i = 1'b0;
    wait_to(118);
    pll_lock_i = 1'b1;
    push(120, 3'd1, F_WAIT, 2'd0);
    push(121, 3'd2, F_WAIT, 2'd0);
    push(377, 3'd3, F_RUN, 2'd0);
    wait_to(376);
    check("glitch_ready_delayed", {31'd0, ready_o}, 32'd0);
    wait_to(380);
    check("drain_s3", exp_q.size(), 32'd0);

    // asynchronous reset while in STABLE
    start(1'b1);
    push(16, 3'd1, F_WAIT, 2'd0);
    push(17, 3'd2, F_WAIT, 2'd0);
    wait_to(50);
    check("drain_s4", exp_q.size(), 32'd0);
    check("stable_before_rst", {29'd0, state_o}, 32'd2);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_values", out_word(), RESET_WORD);
    #20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
